// File: rtl/lenet_pkg.sv
// Shared constants and types for the LeNet inter-layer pipeline.
//
// Holds the default fixed-point sample format, the channel/depth shape of
// each inter-layer feature map, and small helpers used by the feature-map
// buffers.
//
// No ports: imported as lenet_pkg::* by the buffer modules.

package lenet_pkg;

    // Fixed-point sample format.
    localparam int unsigned SampleW = 16;
    typedef logic signed [SampleW-1:0] sample_t;

    // Feature-map shapes: channels per word and words (positions) per frame.
    localparam int unsigned C1Ch    = 6;
    localparam int unsigned C1Depth = 784;   // 28x28
    localparam int unsigned S2Ch    = 6;
    localparam int unsigned S2Depth = 196;   // 14x14
    localparam int unsigned C3Ch    = 16;
    localparam int unsigned C3Depth = 100;   // 10x10
    localparam int unsigned F4Ch    = 16;
    localparam int unsigned F4Depth = 128;

    // Count of completed frames held by a ping-pong buffer (0, 1 or 2).
    typedef logic [1:0] frame_cnt_t;
    localparam frame_cnt_t FramesNone = 2'd0;
    localparam frame_cnt_t FramesMax  = 2'd2;

    // Address width for a given depth; never narrower than one bit.
    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fmap_sdp_ram.sv
// Simple dual-port feature-map bank: DEPTH words of CH lanes x DW bits.
//
// One write port with a per-lane write enable (byte-enable style, so it maps
// onto block RAM) and one read port with a registered output. The memory
// array itself is never reset; only the output register is, so the buffer
// presents zero read data out of reset.
//
// Ports:
//   clk    - clock
//   rst_n  - asynchronous active-low reset (read register only)
//   we     - write enable
//   waddr  - write address
//   wlane  - per-lane write enable, bit i gates lane i
//   wdata  - write word, lane i at [i*DW +: DW]
//   re     - read enable; rdata holds when low
//   raddr  - read address
//   rdata  - registered read word, lane i at [i*DW +: DW]

module fmap_sdp_ram #(
    parameter int unsigned CH    = lenet_pkg::F4Ch,
    parameter int unsigned DW    = lenet_pkg::SampleW,
    parameter int unsigned DEPTH = lenet_pkg::F4Depth,
    localparam int unsigned AW   = lenet_pkg::addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [CH-1:0]    wlane,
    input  logic [CH*DW-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [CH*DW-1:0] rdata
);

    logic [CH*DW-1:0] mem [DEPTH];

    // Lanes with a cleared enable keep their previous contents.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < CH; i++) begin
                if (wlane[i]) begin
                    mem[waddr][i*DW +: DW] <= wdata[i*DW +: DW];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fmap_pingpong_ram.sv
// Two-bank ping-pong feature-map buffer between LeNet layers.
//
// The producer fills the bank selected by wr_bank and pulses wr_done when the
// frame is complete; the consumer reads the bank selected by rd_bank and
// pulses rd_done when finished. full_cnt counts completed frames not yet
// consumed. With one frame held the two pointers always differ, with none
// reads are refused and with two writes are refused, so the producer and
// consumer can never touch the same bank and no bypass path is required.
//
// Illegal operations (strobe while not ready, address out of range) are
// dropped without side effects and raise the sticky err flag.
//
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   wr_en        - write strobe
//   wr_addr      - word address within the current write bank
//   wr_ch_mask   - per-lane write enable
//   wr_data      - write word, lane i at [i*DW +: DW]
//   wr_done      - producer finished current frame
//   wr_ready     - a bank is free for writing
//   rd_en        - read strobe
//   rd_addr      - word address within the current read bank
//   rd_done      - consumer finished current frame
//   rd_ready     - a completed frame is available
//   rd_data      - registered read word (1-cycle latency), holds when idle
//   rd_valid     - rd_data was updated this cycle
//   err          - sticky illegal-access flag

module fmap_pingpong_ram #(
    parameter int unsigned CH    = lenet_pkg::F4Ch,
    parameter int unsigned DW    = lenet_pkg::SampleW,
    parameter int unsigned DEPTH = lenet_pkg::F4Depth,
    localparam int unsigned AW   = lenet_pkg::addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [CH-1:0]    wr_ch_mask,
    input  logic [CH*DW-1:0] wr_data,
    input  logic             wr_done,
    output logic             wr_ready,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    input  logic             rd_done,
    output logic             rd_ready,
    output logic [CH*DW-1:0] rd_data,
    output logic             rd_valid,
    output logic             err
);

    import lenet_pkg::*;

    // One extra bit so an AW-bit address can be compared against DEPTH even
    // when DEPTH is a power of two.
    localparam logic [AW:0] DepthLim = (AW+1)'(DEPTH);

    logic       wr_bank_q, wr_bank_d;
    logic       rd_bank_q, rd_bank_d;
    frame_cnt_t full_cnt_q, full_cnt_d;
    logic       rd_sel_q;
    logic       rd_valid_q;
    logic       err_q, err_d;

    logic wr_addr_ok, rd_addr_ok;
    logic wr_accept, rd_accept;
    logic wr_done_ok, rd_done_ok;
    logic err_set;

    logic [CH*DW-1:0] bank_rdata [2];

    assign wr_ready = (full_cnt_q != FramesMax);
    assign rd_ready = (full_cnt_q != FramesNone);

    assign wr_addr_ok = ({1'b0, wr_addr} < DepthLim);
    assign rd_addr_ok = ({1'b0, rd_addr} < DepthLim);

    assign wr_accept  = wr_en & wr_ready & wr_addr_ok;
    assign rd_accept  = rd_en & rd_ready & rd_addr_ok;
    assign wr_done_ok = wr_done & wr_ready;
    assign rd_done_ok = rd_done & rd_ready;

    assign err_set = (wr_en & ~(wr_ready & wr_addr_ok))
                   | (rd_en & ~(rd_ready & rd_addr_ok))
                   | (wr_done & ~wr_ready)
                   | (rd_done & ~rd_ready);

    // Pointer and frame-count update. Accesses in the same cycle as a done
    // pulse use the pointer values from before the toggle.
    always_comb begin
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        full_cnt_d = full_cnt_q;
        err_d      = err_q | err_set;

        if (wr_done_ok) begin
            wr_bank_d = ~wr_bank_q;
        end
        if (rd_done_ok) begin
            rd_bank_d = ~rd_bank_q;
        end

        case ({wr_done_ok, rd_done_ok})
            2'b10:   full_cnt_d = full_cnt_q + 2'd1;
            2'b01:   full_cnt_d = full_cnt_q - 2'd1;
            default: full_cnt_d = full_cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            full_cnt_q <= FramesNone;
            rd_sel_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            full_cnt_q <= full_cnt_d;
            rd_valid_q <= rd_accept;
            err_q      <= err_d;
            // Remember which bank produced the last read so rd_data keeps
            // showing it after rd_bank toggles.
            if (rd_accept) begin
                rd_sel_q <= rd_bank_q;
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fmap_sdp_ram #(
            .CH    (CH),
            .DW    (DW),
            .DEPTH (DEPTH)
        ) u_ram (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (wr_accept && (wr_bank_q == 1'(b))),
            .waddr (wr_addr),
            .wlane (wr_ch_mask),
            .wdata (wr_data),
            .re    (rd_accept && (rd_bank_q == 1'(b))),
            .raddr (rd_addr),
            .rdata (bank_rdata[b])
        );
    end

    assign rd_data  = bank_rdata[rd_sel_q];
    assign rd_valid = rd_valid_q;
    assign err      = err_q;

endmodule

// File: tb/tb_fmap_pingpong_ram.sv
module tb_fmap_pingpong_ram;

    localparam int CH = 16;
    localparam int DW = 16;
    localparam int DEPTH = 128;
    localparam int AW = 7;
    localparam int W = CH * DW;

    logic clk;
    logic rst_n;

    // Main instance (DEPTH = 128)
    logic          wr_en, wr_done, wr_ready, rd_en, rd_done, rd_ready, rd_valid, err;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [CH-1:0] wr_ch_mask;
    logic [W-1:0]  wr_data, rd_data;

    // Second instance with a non-power-of-two depth (DEPTH = 100)
    logic          d2_wr_en, d2_wr_done, d2_wr_ready, d2_rd_en, d2_rd_done, d2_rd_ready;
    logic          d2_rd_valid, d2_err;
    logic [AW-1:0] d2_wr_addr, d2_rd_addr;
    logic [CH-1:0] d2_wr_ch_mask;
    logic [W-1:0]  d2_wr_data, d2_rd_data;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: two banks of lanes, bank pointers, frame count.
    logic [DW-1:0] m_mem [2][DEPTH][CH];
    int            m_wb, m_rb, m_cnt;
    logic          m_err, m_valid;
    logic [W-1:0]  m_rdata;

    fmap_pingpong_ram #(.CH(CH), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_ch_mask(wr_ch_mask), .wr_data(wr_data),
        .wr_done(wr_done), .wr_ready(wr_ready),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_done(rd_done), .rd_ready(rd_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .err(err)
    );

    fmap_pingpong_ram #(.CH(CH), .DW(DW), .DEPTH(100)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .wr_en(d2_wr_en), .wr_addr(d2_wr_addr), .wr_ch_mask(d2_wr_ch_mask),
        .wr_data(d2_wr_data), .wr_done(d2_wr_done), .wr_ready(d2_wr_ready),
        .rd_en(d2_rd_en), .rd_addr(d2_rd_addr), .rd_done(d2_rd_done),
        .rd_ready(d2_rd_ready), .rd_data(d2_rd_data), .rd_valid(d2_rd_valid), .err(d2_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] w;
        for (int k = 0; k < W / 32; k++) w[k*32 +: 32] = $urandom();
        return w;
    endfunction

    function automatic logic [W-1:0] model_word(input int bank, input int addr);
        logic [W-1:0] w;
        for (int i = 0; i < CH; i++) w[i*DW +: DW] = m_mem[bank][addr][i];
        return w;
    endfunction

    task automatic idle();
        wr_en = 0; wr_addr = '0; wr_ch_mask = '0; wr_data = '0; wr_done = 0;
        rd_en = 0; rd_addr = '0; rd_done = 0;
        d2_wr_en = 0; d2_wr_addr = '0; d2_wr_ch_mask = '0; d2_wr_data = '0; d2_wr_done = 0;
        d2_rd_en = 0; d2_rd_addr = '0; d2_rd_done = 0;
    endtask

    task automatic model_reset();
        m_wb = 0; m_rb = 0; m_cnt = 0; m_err = 0; m_valid = 0; m_rdata = '0;
    endtask

    // Advance the model by the current main-instance inputs, then clock once.
    task automatic tick();
        bit wr_ok, rd_ok;
        wr_ok = (m_cnt < 2);
        rd_ok = (m_cnt > 0);
        if (rd_en && rd_ok) begin
            m_rdata = model_word(m_rb, int'(rd_addr));
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
        if (wr_en && wr_ok)
            for (int i = 0; i < CH; i++)
                if (wr_ch_mask[i]) m_mem[m_wb][wr_addr][i] = wr_data[i*DW +: DW];
        if (((wr_en || wr_done) && !wr_ok) || ((rd_en || rd_done) && !rd_ok)) m_err = 1'b1;
        if (wr_done && wr_ok) begin m_wb = 1 - m_wb; m_cnt++; end
        if (rd_done && rd_ok) begin m_rb = 1 - m_rb; m_cnt--; end
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int addr, input logic [CH-1:0] mask, input logic [W-1:0] data);
        wr_en = 1; wr_addr = AW'(addr); wr_ch_mask = mask; wr_data = data;
        tick();
        wr_en = 0;
    endtask

    task automatic do_read(input int addr);
        rd_en = 1; rd_addr = AW'(addr);
        tick();
        rd_en = 0;
    endtask

    task automatic do_done(input logic w, input logic r);
        wr_done = w; rd_done = r;
        tick();
        wr_done = 0; rd_done = 0;
    endtask

    task automatic apply_reset();
        idle();
        rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_vec++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
        n_vec++; if (rd_data !== '0) begin n_bad++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
        n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
        n_vec++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready); end
        n_vec++; if (rd_ready !== 1'b0) begin n_bad++; $display("FAIL reset_rd_ready: got %b want 0", rd_ready); end
    endtask

    task automatic test_fill_and_read();
        logic [W-1:0] w;
        for (int a = 0; a < DEPTH; a++) begin
            for (int i = 0; i < CH; i++) w[i*DW +: DW] = {8'(a), 8'(i)};
            do_write(a, '1, w);
        end
        do_done(1, 0);
        n_vec++; if (rd_ready !== 1'b1) begin n_bad++; $display("FAIL fill_rd_ready: got %b want 1", rd_ready); end
        n_vec++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL fill_wr_ready: got %b want 1", wr_ready); end
        do_read(5);
        n_vec++; if (rd_valid !== 1'b1) begin n_bad++; $display("FAIL fill_rd_valid: got %b want 1", rd_valid); end
        n_vec++; if (rd_data[3*DW +: DW] !== 16'h0503) begin n_bad++; $display("FAIL fill_lane3: got %h want 0503", rd_data[3*DW +: DW]); end
        n_vec++; if (rd_data !== m_rdata) begin n_bad++; $display("FAIL fill_word: got %h want %h", rd_data, m_rdata); end
        tick();
        n_vec++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL fill_valid_drop: got %b want 0", rd_valid); end
        n_vec++; if (rd_data !== m_rdata) begin n_bad++; $display("FAIL fill_hold: got %h want %h", rd_data, m_rdata); end
        do_done(0, 1);
    endtask

    task automatic test_full_overflow();
        int addrs [4] = '{0, 1, 64, 127};
        apply_reset();
        for (int a = 0; a < DEPTH; a++) do_write(a, '1, rand_word());
        do_done(1, 0);
        for (int a = 0; a < DEPTH; a++) do_write(a, '1, rand_word());
        do_done(1, 0);
        n_vec++; if (wr_ready !== 1'b0) begin n_bad++; $display("FAIL full_wr_ready: got %b want 0", wr_ready); end
        n_vec++; if (rd_ready !== 1'b1) begin n_bad++; $display("FAIL full_rd_ready: got %b want 1", rd_ready); end
        do_write(0, '1, rand_word());
        n_vec++; if (err !== 1'b1) begin n_bad++; $display("FAIL full_err: got %b want 1", err); end
        for (int b = 0; b < 2; b++) begin
            foreach (addrs[k]) begin
                do_read(addrs[k]);
                n_vec++; if (rd_data !== m_rdata || rd_valid !== 1'b1) begin n_bad++; $display("FAIL full_readback b%0d a%0d: got %h/%b want %h/1", b, addrs[k], rd_data, rd_valid, m_rdata); end
            end
            do_done(0, 1);
        end
    endtask

    task automatic test_lane_mask();
        logic [W-1:0] exp_w;
        apply_reset();
        do_write(7, '1, {CH{16'hAAAA}});
        do_write(7, 16'h0001, {CH{16'h5555}});
        do_done(1, 0);
        do_read(7);
        exp_w = {{(CH-1){16'hAAAA}}, 16'h5555};
        n_vec++; if (rd_data !== exp_w) begin n_bad++; $display("FAIL lane_mask: got %h want %h", rd_data, exp_w); end
        n_vec++; if (rd_data !== m_rdata) begin n_bad++; $display("FAIL lane_mask_model: got %h want %h", rd_data, m_rdata); end
        do_done(0, 1);
    endtask

    task automatic test_simul_done();
        logic [W-1:0] exp_w [4];
        for (int a = 0; a < 4; a++) do_write(a, '1, rand_word());
        do_done(1, 0);
        for (int a = 0; a < 4; a++) begin
            exp_w[a] = rand_word();
            do_write(a, '1, exp_w[a]);
        end
        // Final write of the frame shares the cycle with both done pulses.
        exp_w[3] = rand_word();
        wr_en = 1; wr_addr = 3; wr_ch_mask = '1; wr_data = exp_w[3];
        wr_done = 1; rd_done = 1;
        tick();
        idle();
        n_vec++; if (rd_ready !== 1'b1 || wr_ready !== 1'b1) begin n_bad++; $display("FAIL simul_ready: got %b%b want 11", rd_ready, wr_ready); end
        for (int a = 0; a < 4; a++) begin
            do_read(a);
            n_vec++; if (rd_data !== exp_w[a]) begin n_bad++; $display("FAIL simul_read a%0d: got %h want %h", a, rd_data, exp_w[a]); end
        end
        do_done(0, 1);
        n_vec++; if (rd_ready !== 1'b0) begin n_bad++; $display("FAIL simul_drain: got %b want 0", rd_ready); end
    endtask

    task automatic test_empty_read();
        logic [W-1:0] prev;
        prev = m_rdata;
        do_read(2);
        n_vec++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL empty_rd_valid: got %b want 0", rd_valid); end
        n_vec++; if (rd_data !== prev) begin n_bad++; $display("FAIL empty_rd_data: got %h want %h", rd_data, prev); end
        n_vec++; if (err !== 1'b1) begin n_bad++; $display("FAIL empty_err: got %b want 1", err); end
    endtask

    task automatic test_bad_addr();
        logic [W-1:0] w_ok;
        w_ok = rand_word();
        d2_wr_en = 1; d2_wr_addr = 99; d2_wr_ch_mask = '1; d2_wr_data = w_ok;
        tick();
        d2_wr_en = 0;
        n_vec++; if (d2_err !== 1'b0) begin n_bad++; $display("FAIL bad_addr_legal_err: got %b want 0", d2_err); end
        d2_wr_en = 1; d2_wr_addr = 100; d2_wr_data = rand_word();
        tick();
        d2_wr_en = 0;
        n_vec++; if (d2_err !== 1'b1) begin n_bad++; $display("FAIL bad_addr_err: got %b want 1", d2_err); end
        d2_wr_done = 1;
        tick();
        d2_wr_done = 0;
        d2_rd_en = 1; d2_rd_addr = 99;
        tick();
        d2_rd_en = 0;
        n_vec++; if (d2_rd_valid !== 1'b1 || d2_rd_data !== w_ok) begin n_bad++; $display("FAIL bad_addr_readback: got %h/%b want %h/1", d2_rd_data, d2_rd_valid, w_ok); end
        d2_rd_en = 1; d2_rd_addr = 120;
        tick();
        d2_rd_en = 0;
        n_vec++; if (d2_rd_valid !== 1'b0 || d2_rd_data !== w_ok) begin n_bad++; $display("FAIL bad_addr_read_reject: got %h/%b want %h/0", d2_rd_data, d2_rd_valid, w_ok); end
    endtask

    task automatic test_random();
        logic [W+3:0] obs, exp_v;
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            wr_en      = (m_cnt < 2) && ($urandom_range(0, 2) != 0);
            wr_addr    = AW'($urandom());
            wr_ch_mask = CH'($urandom());
            wr_data    = rand_word();
            wr_done    = (m_cnt < 2) && ($urandom_range(0, 15) == 0);
            rd_en      = (m_cnt > 0) && ($urandom_range(0, 1) != 0);
            rd_addr    = AW'($urandom());
            rd_done    = (m_cnt > 0) && ($urandom_range(0, 15) == 0);
            tick();
            obs   = {rd_valid, err, wr_ready, rd_ready, rd_data};
            exp_v = {m_valid, m_err, (m_cnt != 2), (m_cnt != 0), m_rdata};
            n_vec++; if (obs !== exp_v) begin n_bad++; $display("FAIL random c%0d: got %h want %h", c, obs, exp_v); end
        end
        idle();
    endtask

    task automatic test_async_reset();
        while (m_cnt < 2) do_done(1, 0);
        do_write(0, '1, rand_word());
        n_vec++; if (err !== 1'b1) begin n_bad++; $display("FAIL areset_pre_err: got %b want 1", err); end
        rd_en = 1; rd_addr = 5;
        tick();
        n_vec++; if (rd_valid !== 1'b1) begin n_bad++; $display("FAIL areset_pre_valid: got %b want 1", rd_valid); end
        #2;
        rst_n = 0;
        model_reset();
        #1;
        n_vec++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL areset_rd_valid: got %b want 0", rd_valid); end
        n_vec++; if (rd_data !== '0) begin n_bad++; $display("FAIL areset_rd_data: got %h want 0", rd_data); end
        n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL areset_err: got %b want 0", err); end
        n_vec++; if (rd_ready !== 1'b0 || wr_ready !== 1'b1) begin n_bad++; $display("FAIL areset_ready: got rd%b wr%b want rd0 wr1", rd_ready, wr_ready); end
        rd_en = 0;
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        n_vec++; if (wr_ready !== 1'b1 || rd_ready !== 1'b0 || rd_valid !== 1'b0) begin n_bad++; $display("FAIL areset_release: got wr%b rd%b v%b want wr1 rd0 v0", wr_ready, rd_ready, rd_valid); end
    endtask

    initial begin
        rst_n = 0;
        idle();
        model_reset();
        test_reset();
        test_fill_and_read();
        test_full_overflow();
        test_lane_mask();
        test_simul_done();
        test_empty_read();
        test_bad_addr();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
